csrng_state_store: RTL
======================

CSRNG_STATE_STORE -- requirements
Module: csrng_state_store

Interface
REQ-001 SHALL have parameter NApps, default 4, number of instance entries (1..16).
REQ-002 SHALL have parameter StateId, default 4, instance ID width.
REQ-003 SHALL have parameter KeyLen, default 256, key width.
REQ-004 SHALL have parameter BlkLen, default 128, V width.
REQ-005 SHALL have parameter CtrLen, default 32, reseed counter width.
REQ-006 SHALL have ports clk_i in 1, clock; rst_ni in 1, reset, asynchronous, active-low.
REQ-007 SHALL have ports enable_i in 1, block enable; clear_i in 1, zeroize request pulse.
REQ-008 SHALL have read ports rd_req_i in 1; rd_id_i in StateId; rd_vld_o out 1; rd_key_o out KeyLen; rd_v_o out BlkLen; rd_ctr_o out CtrLen; rd_inst_st_o out 1; rd_fips_o out 1; rd_err_o out 1.
REQ-009 SHALL have write ports wr_req_i in 1; wr_rdy_o out 1; wr_id_i in StateId; wr_fips_i in 1; wr_inst_st_i in 1; wr_key_i in KeyLen; wr_v_i in BlkLen; wr_ctr_i in CtrLen.
REQ-010 SHALL have status ports sts_ack_o out 1, sts_err_o out 1, sts_id_o out StateId.
REQ-011 SHALL have diagnostic ports diag_en_i in 1; diag_id_i in StateId; diag_restart_i in 1; diag_next_i in 1; diag_val_o out 32.

Function
REQ-012 Entry SHALL be {fips, inst_st, key, v, ctr}, W = 2+KeyLen+BlkLen+CtrLen bits, flops without reset.
REQ-013 Write SHALL occur when wr_req_i && wr_rdy_o && enable_i && wr_id_i < NApps; entry updated next edge.
REQ-014 wr_rdy_o SHALL be 1 in IDLE, 0 in ZERO.
REQ-015 Every accepted wr_req_i SHALL give sts_ack_o=1 for exactly one cycle, 1 cycle later, with sts_id_o=wr_id_i; sts_err_o=1 and no update if wr_id_i >= NApps.
REQ-016 Read: rd_req_i && enable_i SHALL give rd_vld_o=1 and registered data exactly 1 cycle later; outputs hold last value when rd_vld_o=0.
REQ-017 Read of id >= NApps SHALL return all-zero data with rd_vld_o=1.
REQ-018 Same-cycle read and write to same id SHALL return pre-write contents.
REQ-019 FSM states IDLE, ZERO. IDLE->ZERO on clear_i or enable_i falling edge; ZERO clears entry ptr (0..NApps-1) per cycle; ZERO->IDLE after entry NApps-1 cleared (NApps cycles).
REQ-020 clear_i in ZERO SHALL restart ptr at 0; rd_req_i in ZERO SHALL return zeros.
REQ-021 Diagnostic word count NW = ceil(W/32); diag_val_o = word ptr of entry diag_id_i, zero-padded above W.
REQ-022 Word ptr SHALL reset to 0 on diag_restart_i (priority), increment on diag_next_i, wrap NW-1 -> 0.
REQ-023 diag_val_o SHALL be 0 when diag_en_i=0, enable_i=0, or diag_id_i >= NApps.

Reset
REQ-024 Reset SHALL set FSM=ZERO with ptr 0 (entries zeroized after reset), all outputs 0 except wr_rdy_o=0, word ptr 0.
REQ-025 Reset mid-ZERO SHALL restart zeroization from entry 0.

Configuration
REQ-026 CSRNG_STATE_STORE_PARITY_EN defined: each entry SHALL store one even-parity bit computed on write, rd_err_o=1 alongside rd_vld_o on mismatch; zeroized entries have parity 0.
REQ-027 CSRNG_STATE_STORE_PARITY_EN undefined: no parity storage, rd_err_o tied 0.

Verification
REQ-028 Reset release -> wr_rdy_o=0 for 4 cycles, then 1; read id 2 -> all zeros.
REQ-029 Write id 1 key=0xA5.., ctr=7 -> sts_ack_o 1 cycle later, sts_id_o=1; read id 1 next cycle -> key 0xA5.., ctr 7.
REQ-030 Write id 5 with NApps=4 -> sts_ack_o=1, sts_err_o=1; all entries unchanged.
REQ-031 Same-cycle write ctr=9 and read id 0 (old ctr=3) -> rd_ctr_o=3; next read -> 9.
REQ-032 diag_id_i=0, diag_restart_i then 14 diag_next_i pulses (default params) -> words 0..13 in order, then wrap to word 0; word 13 upper 30 bits 0.
REQ-033 With parity macro, force bit flip in entry 2, read id 2 -> rd_err_o=1; clear_i -> entries zero, rd_err_o=0.

Source files
------------

// File: rtl/csrng_state_store.sv
// CSRNG instance state store: per-instance {fips, inst_st, key, v, ctr} with zeroization and diag readout.
// Optional parity protection per entry: define CSRNG_STATE_STORE_PARITY_EN.
module csrng_state_store #(
    parameter int NApps   = 4,
    parameter int StateId = 4,
    parameter int KeyLen  = 256,
    parameter int BlkLen  = 128,
    parameter int CtrLen  = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enable_i,
    input  logic               clear_i,
    input  logic               rd_req_i,
    input  logic [StateId-1:0] rd_id_i,
    output logic               rd_vld_o,
    output logic [KeyLen-1:0]  rd_key_o,
    output logic [BlkLen-1:0]  rd_v_o,
    output logic [CtrLen-1:0]  rd_ctr_o,
    output logic               rd_inst_st_o,
    output logic               rd_fips_o,
    output logic               rd_err_o,
    input  logic               wr_req_i,
    output logic               wr_rdy_o,
    input  logic [StateId-1:0] wr_id_i,
    input  logic               wr_fips_i,
    input  logic               wr_inst_st_i,
    input  logic [KeyLen-1:0]  wr_key_i,
    input  logic [BlkLen-1:0]  wr_v_i,
    input  logic [CtrLen-1:0]  wr_ctr_i,
    output logic               sts_ack_o,
    output logic               sts_err_o,
    output logic [StateId-1:0] sts_id_o,
    input  logic               diag_en_i,
    input  logic [StateId-1:0] diag_id_i,
    input  logic               diag_restart_i,
    input  logic               diag_next_i,
    output logic [31:0]        diag_val_o
);
    localparam int W    = 2 + KeyLen + BlkLen + CtrLen;
    localparam int NW   = (W + 31) / 32;
    localparam int IdxW = (NApps > 1) ? $clog2(NApps) : 1;
    localparam int WpW  = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic {IDLE, ZERO} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic            enable_q;
    logic [WpW-1:0]  wptr_q;

    logic [W-1:0] mem [NApps];

    logic            wr_acc, wr_ok, wr_en, zero_we, rd_ok, rd_en, diag_ok;
    logic [IdxW-1:0] wr_idx, rd_idx, diag_idx;
    logic [W-1:0]    wr_data, rd_ent;

    assign wr_rdy_o = (state_q == IDLE);
    assign wr_ok    = 32'(wr_id_i) < NApps;
    assign wr_acc   = wr_req_i && wr_rdy_o && enable_i;
    assign wr_en    = wr_acc && wr_ok;
    assign zero_we  = (state_q == ZERO);
    assign wr_idx   = IdxW'(wr_id_i);
    assign wr_data  = {wr_fips_i, wr_inst_st_i, wr_key_i, wr_v_i, wr_ctr_i};

    assign rd_en  = rd_req_i && enable_i;
    assign rd_ok  = (32'(rd_id_i) < NApps) && (state_q == IDLE);
    assign rd_idx = IdxW'(rd_id_i);
    assign rd_ent = rd_ok ? mem[rd_idx] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ZERO;
            ptr_q    <= '0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            enable_q <= enable_i;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (clear_i || (enable_q && !enable_i)) begin
                    state_d = ZERO;
                    ptr_d   = '0;
                end
            end
            ZERO: begin
                if (clear_i) begin
                    ptr_d = '0;
                end else if (ptr_q == IdxW'(NApps - 1)) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = ZERO;
                ptr_d   = '0;
            end
        endcase
    end

    // Storage is deliberately unreset; the ZERO sweep after reset scrubs it.
    always_ff @(posedge clk_i) begin
        if (zero_we) begin
            mem[ptr_q] <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

`ifdef CSRNG_STATE_STORE_PARITY_EN
    logic par_mem [NApps];
    logic rd_err_q;

    always_ff @(posedge clk_i) begin
        if (zero_we) begin
            par_mem[ptr_q] <= 1'b0;
        end else if (wr_en) begin
            par_mem[wr_idx] <= ^wr_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_err_q <= 1'b0;
        end else if (rd_en) begin
            rd_err_q <= rd_ok && (par_mem[rd_idx] != ^mem[rd_idx]);
        end
    end
    assign rd_err_o = rd_err_q;
`else
    assign rd_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_vld_o     <= 1'b0;
            rd_fips_o    <= 1'b0;
            rd_inst_st_o <= 1'b0;
            rd_key_o     <= '0;
            rd_v_o       <= '0;
            rd_ctr_o     <= '0;
        end else begin
            rd_vld_o <= rd_en;
            if (rd_en) begin
                {rd_fips_o, rd_inst_st_o, rd_key_o, rd_v_o, rd_ctr_o} <= rd_ent;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sts_ack_o <= 1'b0;
            sts_err_o <= 1'b0;
            sts_id_o  <= '0;
        end else begin
            sts_ack_o <= wr_acc;
            sts_err_o <= wr_acc && !wr_ok;
            if (wr_acc) sts_id_o <= wr_id_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
        end else if (diag_restart_i) begin
            wptr_q <= '0;
        end else if (diag_next_i) begin
            wptr_q <= (wptr_q == WpW'(NW - 1)) ? '0 : wptr_q + 1'b1;
        end
    end

    logic [NW-1:0][31:0] diag_words;
    assign diag_ok    = diag_en_i && enable_i && (32'(diag_id_i) < NApps);
    assign diag_idx   = IdxW'(diag_id_i);
    assign diag_words = (NW * 32)'(mem[diag_idx]);
    assign diag_val_o = diag_ok ? diag_words[wptr_q] : 32'h0;

endmodule
